// File: rtl/druaga_sprite_sched.sv
// Per-scanline sprite scheduler: scans 64 attribute entries on HBLANK entry and queues render jobs.
// Optional macro SPR_LIMIT_EN caps the number of jobs per line at MAX_PER_LINE.
module druaga_sprite_sched #(
    parameter int DEPTH = 4
`ifdef SPR_LIMIT_EN
    ,
    parameter int MAX_PER_LINE = 16
`endif
) (
    input  logic        VCLK,
    input  logic        RESET,
    input  logic        HBLANK,
    input  logic [8:0]  VPOS,
    output logic [6:0]  SPRA_A,
    input  logic [23:0] SPRA_D,
    output logic        JOB_VALID,
    input  logic        JOB_READY,
    output logic [7:0]  JOB_CNO,
    output logic [4:0]  JOB_SY,
    output logic [4:0]  JOB_XF,
    output logic [5:0]  JOB_PN,
    output logic [8:0]  JOB_SX,
    output logic        JOB_W32,
    output logic        LINE_DONE,
    output logic        LINE_TRUNC,
    output logic [2:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        EV0  = 3'd2,
        RD1  = 3'd3,
        EV1  = 3'd4,
        PUSH = 3'd5
    } state_t;

    typedef struct packed {
        logic [7:0] cno;
        logic [4:0] sy;
        logic [4:0] xf;
        logic [5:0] pn;
        logic [8:0] sx;
        logic       w32;
    } job_t;

    state_t        state;
    logic [5:0]    idx;
    logic [8:0]    vline;
    logic          hb_q;
    job_t          lat_job;
    job_t          fifo_mem [DEPTH];
    job_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          hb_rise;
    logic          full;
    logic          push;
    logic          pop;
    logic          last;
    logic [5:0]    idx_next;
    logic          limit_reached;

    logic          sizy;
    logic          sizx;
    logic [8:0]    y;
    logic [8:0]    m;
    logic          hit;
    logic [4:0]    yf;
    logic          unused_spra;

    // Handshake: a job transfers on every rising VCLK where JOB_VALID and JOB_READY are both high.
    // JOB_VALID never depends on JOB_READY; the head job is stable until accepted or flushed by a new scan.

    assign hb_rise  = HBLANK & ~hb_q;
    assign full     = (count == CW'(DEPTH));
    assign pop      = JOB_VALID & JOB_READY & ~hb_rise;
    assign push     = (state == PUSH) & ~hb_rise & (~full | pop);
    assign last     = (idx == 6'd63);
    assign idx_next = idx + 6'd1;

    assign sizy = SPRA_D[19];
    assign sizx = SPRA_D[18];
    assign y    = {1'b0, SPRA_D[15:8]} + 9'h010 + vline;
    assign m    = {1'b1, 8'hF0 ^ {3'b000, sizy, 4'h0}};
    assign hit  = ((y & m) == {1'b0, m[7:0]});
    assign yf   = SPRA_D[17] ? {sizy, 4'hF} : 5'h00;
    assign unused_spra = ^SPRA_D[23:20];

`ifdef SPR_LIMIT_EN
    logic [6:0] hit_cnt;
    assign limit_reached = ((hit_cnt + 7'd1) == 7'(MAX_PER_LINE));

    always_ff @(posedge VCLK) begin
        if (RESET || hb_rise) begin
            hit_cnt <= '0;
        end else if (push) begin
            hit_cnt <= hit_cnt + 7'd1;
        end
    end
`else
    assign limit_reached = 1'b0;
`endif

    always_ff @(posedge VCLK) begin
        if (RESET) begin
            state      <= IDLE;
            idx        <= '0;
            vline      <= '0;
            hb_q       <= 1'b0;
            SPRA_A     <= '0;
            LINE_DONE  <= 1'b0;
            LINE_TRUNC <= 1'b0;
            lat_job    <= '0;
        end else begin
            hb_q       <= HBLANK;
            LINE_DONE  <= 1'b0;
            LINE_TRUNC <= 1'b0;
            if (hb_rise) begin
                // A scan still in flight when the next blank arrives is abandoned.
                if (state != IDLE) begin
                    LINE_TRUNC <= 1'b1;
                end
                vline  <= VPOS + 9'd1;
                idx    <= '0;
                SPRA_A <= '0;
                state  <= RD0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RD0:  state <= EV0;
                    EV0: begin
                        if (hit) begin
                            lat_job.cno <= SPRA_D[7:0] & {6'h3F, ~sizy, ~sizx};
                            lat_job.xf  <= SPRA_D[16] ? {sizx, 4'hF} : 5'h00;
                            lat_job.sy  <= (y[4:0] & {sizy, 4'hF}) ^ yf;
                            lat_job.w32 <= sizx;
                            SPRA_A      <= {idx, 1'b1};
                            state       <= RD1;
                        end else if (last) begin
                            LINE_DONE <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx    <= idx_next;
                            SPRA_A <= {idx_next, 1'b0};
                            state  <= RD0;
                        end
                    end
                    RD1: state <= EV1;
                    EV1: begin
                        lat_job.pn <= SPRA_D[5:0];
                        lat_job.sx <= {SPRA_D[16], SPRA_D[15:8]} - 9'h038;
                        state      <= PUSH;
                    end
                    PUSH: begin
                        if (push) begin
                            if (limit_reached) begin
                                LINE_TRUNC <= 1'b1;
                                state      <= IDLE;
                            end else if (last) begin
                                LINE_DONE <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                idx    <= idx_next;
                                SPRA_A <= {idx_next, 1'b0};
                                state  <= RD0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Job FIFO; a new scan flushes it ahead of any same-cycle push or pop.
    always_ff @(posedge VCLK) begin
        if (RESET || hb_rise) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge VCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= lat_job;
        end
    end

    assign head      = fifo_mem[rd_ptr];
    assign JOB_VALID = (count != '0);
    assign JOB_CNO   = head.cno;
    assign JOB_SY    = head.sy;
    assign JOB_XF    = head.xf;
    assign JOB_PN    = head.pn;
    assign JOB_SX    = head.sx;
    assign JOB_W32   = head.w32;
    assign dbg_state = state;

endmodule

// File: tb/tb_druaga_sprite_sched.sv
// Scoreboard bench for druaga_sprite_sched: directed sprite tables, expected jobs queued, monitor compares.
// Builds with or without SPR_LIMIT_EN (limit bench value 2).
module tb_druaga_sprite_sched;

    logic        VCLK;
    logic        RESET;
    logic        HBLANK;
    logic [8:0]  VPOS;
    logic [6:0]  SPRA_A;
    logic [23:0] SPRA_D;
    logic        JOB_VALID;
    logic        JOB_READY;
    logic [7:0]  JOB_CNO;
    logic [4:0]  JOB_SY;
    logic [4:0]  JOB_XF;
    logic [5:0]  JOB_PN;
    logic [8:0]  JOB_SX;
    logic        JOB_W32;
    logic        LINE_DONE;
    logic        LINE_TRUNC;
    logic [2:0]  dbg_state;

`ifdef SPR_LIMIT_EN
    localparam int LIMIT = 2;
`else
    localparam int LIMIT = 64;
`endif

    druaga_sprite_sched #(
        .DEPTH(4)
`ifdef SPR_LIMIT_EN
        ,
        .MAX_PER_LINE(2)
`endif
    ) dut (
        .VCLK(VCLK),
        .RESET(RESET),
        .HBLANK(HBLANK),
        .VPOS(VPOS),
        .SPRA_A(SPRA_A),
        .SPRA_D(SPRA_D),
        .JOB_VALID(JOB_VALID),
        .JOB_READY(JOB_READY),
        .JOB_CNO(JOB_CNO),
        .JOB_SY(JOB_SY),
        .JOB_XF(JOB_XF),
        .JOB_PN(JOB_PN),
        .JOB_SX(JOB_SX),
        .JOB_W32(JOB_W32),
        .LINE_DONE(LINE_DONE),
        .LINE_TRUNC(LINE_TRUNC),
        .dbg_state(dbg_state)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          trunc_cnt = 0;
    logic [33:0] exp_q[$];
    logic [23:0] spr_mem [128];

    // Clock and attribute RAM with one cycle of read latency.
    initial begin
        VCLK = 1'b0;
        forever #5 VCLK = ~VCLK;
    end

    always @(posedge VCLK) begin
        SPRA_D <= spr_mem[SPRA_A];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] make_job(input logic [7:0] cno, input logic [4:0] sy,
                                             input logic [4:0] xf, input logic [5:0] pn,
                                             input logic [8:0] sx, input logic w32);
        return {cno, sy, xf, pn, sx, w32};
    endfunction

    // Plain 16x16 sprite hitting line 0x21 at row 0; every field depends on the index.
    task automatic set_simple(input int i);
        spr_mem[2*i]     = {8'h00, 8'hBF, 8'h80 | 8'(i)};
        spr_mem[2*i + 1] = {8'h00, 8'h40 + 8'(i), 8'h80 | 8'(i)};
    endtask

    function automatic logic [33:0] simple_job(input int i);
        return make_job(8'h80 | 8'(i), 5'h00, 5'h00, 6'(i), 9'h008 + 9'(i), 1'b0);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) begin
            spr_mem[i] = 24'h000000;
        end
    endtask

    task automatic start_line(input logic [8:0] vpos);
        @(posedge VCLK); #1;
        VPOS   = vpos;
        HBLANK = 1'b1;
        @(posedge VCLK); #1;
        @(posedge VCLK); #1;
        HBLANK = 1'b0;
    endtask

    task automatic wait_line_end(input string name, input int done0, input int trunc0,
                                 input int exp_done, input int exp_trunc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge VCLK); #2;
            if (done_cnt != done0 || trunc_cnt != trunc0) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_line_end_seen"}, seen, 1);
        repeat (6) @(posedge VCLK);
        #2;
        check({name, "_jobs_left"}, exp_q.size(), 0);
        check({name, "_done_pulses"}, done_cnt - done0, exp_done);
        check({name, "_trunc_pulses"}, trunc_cnt - trunc0, exp_trunc);
    endtask

    // Monitor: pulse counters and job scoreboard.
    always @(negedge VCLK) begin
        if (!RESET) begin
            if (LINE_DONE) done_cnt++;
            if (LINE_TRUNC) trunc_cnt++;
            if (JOB_VALID && JOB_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL job_unexpected: got 0x%0h, expected no job",
                             {JOB_CNO, JOB_SY, JOB_XF, JOB_PN, JOB_SX, JOB_W32});
                end else begin
                    check("job", {JOB_CNO, JOB_SY, JOB_XF, JOB_PN, JOB_SX, JOB_W32}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, expected test to complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int d0;
        int t0;
        bit seen;
        RESET     = 1'b1;
        HBLANK    = 1'b0;
        VPOS      = 9'h000;
        JOB_READY = 1'b0;
        clear_mem();
        repeat (3) @(posedge VCLK);
        #1 RESET = 1'b0;

        @(negedge VCLK);
        check("rst_job_valid", JOB_VALID, 0);
        check("rst_spra_a", SPRA_A, 0);
        check("rst_line_done", LINE_DONE, 0);
        check("rst_line_trunc", LINE_TRUNC, 0);
        check("rst_state", dbg_state, 0);

        // Single sprite hit.
        @(posedge VCLK); #1;
        spr_mem[10] = 24'h00BF48;
        spr_mem[11] = 24'h01402A;
        exp_q.push_back(make_job(8'h48, 5'h00, 5'h00, 6'h2A, 9'h108, 1'b0));
        JOB_READY = 1'b1;
        d0 = done_cnt; t0 = trunc_cnt;
        start_line(9'h020);
        wait_line_end("single", d0, t0, 1, 0);

        // 32x32 with both flips: y = 0xF0, row 0x10 flipped to 0x0F.
        spr_mem[10] = 24'h0FBF48;
        exp_q.push_back(make_job(8'h48, 5'h0F, 5'h1F, 6'h2A, 9'h108, 1'b1));
        d0 = done_cnt; t0 = trunc_cnt;
        start_line(9'h020);
        wait_line_end("flip", d0, t0, 1, 0);

        // First and last index, cno masking, sx wrap, and a miss with y[8] set.
        clear_mem();
        spr_mem[0]   = 24'h0AB07F;
        spr_mem[1]   = 24'h01FFFF;
        spr_mem[20]  = 24'h00E012;
        spr_mem[21]  = 24'h000012;
        spr_mem[126] = 24'h04C3FF;
        spr_mem[127] = 24'h0010C5;
        exp_q.push_back(make_job(8'h7D, 5'h1E, 5'h00, 6'h3F, 9'h1C7, 1'b0));
        exp_q.push_back(make_job(8'hFE, 5'h04, 5'h00, 6'h05, 9'h1D8, 1'b1));
        d0 = done_cnt; t0 = trunc_cnt;
        start_line(9'h020);
        wait_line_end("edges", d0, t0, (LIMIT > 2) ? 1 : 0, (LIMIT > 2) ? 0 : 1);

`ifndef SPR_LIMIT_EN
        // Backpressure: six hits into a four-deep FIFO.
        clear_mem();
        for (int i = 2; i <= 12; i += 2) begin
            set_simple(i);
            exp_q.push_back(simple_job(i));
        end
        JOB_READY = 1'b0;
        d0 = done_cnt; t0 = trunc_cnt;
        start_line(9'h020);
        repeat (150) @(posedge VCLK);
        @(negedge VCLK);
        check("bp_state_push", dbg_state, 5);
        check("bp_spra_a", SPRA_A, 7'h15);
        check("bp_job_valid", JOB_VALID, 1);
        check("bp_no_done", done_cnt - d0, 0);
        repeat (20) @(negedge VCLK);
        check("bp_spra_frozen", SPRA_A, 7'h15);
        @(posedge VCLK); #1 JOB_READY = 1'b1;
        wait_line_end("bp_drain", d0, t0, 1, 0);

        // Abort: new blank while stalled flushes and rescans from idx 0.
        JOB_READY = 1'b0;
        start_line(9'h020);
        repeat (150) @(posedge VCLK);
        exp_q.delete();
        for (int i = 2; i <= 12; i += 2) begin
            exp_q.push_back(simple_job(i));
        end
        d0 = done_cnt; t0 = trunc_cnt;
        @(posedge VCLK); #1 HBLANK = 1'b1;
        @(posedge VCLK);
        @(negedge VCLK);
        check("abort_trunc_pulse", LINE_TRUNC, 1);
        check("abort_job_valid", JOB_VALID, 0);
        check("abort_spra_a", SPRA_A, 0);
        check("abort_state_rd0", dbg_state, 1);
        @(posedge VCLK); #1 HBLANK = 1'b0;
        @(posedge VCLK); #1 JOB_READY = 1'b1;
        check("abort_trunc_count", trunc_cnt - t0, 1);
        wait_line_end("abort_rescan", d0, t0 + 1, 1, 0);
`else
        // Limit: three hits, only the first two are queued.
        clear_mem();
        set_simple(3);
        set_simple(7);
        set_simple(9);
        exp_q.push_back(simple_job(3));
        exp_q.push_back(simple_job(7));
        JOB_READY = 1'b1;
        d0 = done_cnt; t0 = trunc_cnt;
        start_line(9'h020);
        wait_line_end("limit", d0, t0, 0, 1);
`endif

        // Reset mid-scan at idx 30 with jobs queued.
        clear_mem();
        set_simple(1);
        set_simple(2);
        JOB_READY = 1'b0;
        d0 = done_cnt;
        start_line(9'h020);
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(posedge VCLK); #2;
            if (SPRA_A == 7'd60) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_mid_reached_idx30", seen, 1);
        check("rst_mid_jobs_queued", JOB_VALID, 1);
        RESET = 1'b1;
        @(posedge VCLK);
        @(negedge VCLK);
        check("rst_mid_job_valid", JOB_VALID, 0);
        check("rst_mid_spra_a", SPRA_A, 0);
        check("rst_mid_state", dbg_state, 0);
        exp_q.delete();
        @(posedge VCLK); #1 RESET = 1'b0;
        repeat (200) @(posedge VCLK);
        @(negedge VCLK);
        check("rst_mid_stays_idle", dbg_state, 0);
        check("rst_mid_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
